// File: rtl/speck_datapath_responder_if.sv
// Start/ack handshake and operand/result buses between the control path and the Speck datapath.
// The master drives the request and operands, and the slave returns the ack, busy and ciphertext.
interface speck_datapath_responder_if;
    logic        start_speck;
    logic [63:0] X;
    logic [63:0] K1;
    logic        eqz;
    logic        busy;
    logic [63:0] Y_out;

    modport master (
        output start_speck, X, K1,
        input  eqz, busy, Y_out
    );

    modport slave (
        input  start_speck, X, K1,
        output eqz, busy, Y_out
    );
endinterface

// File: rtl/speck_datapath_responder.sv
// Iterative Speck-style cipher that answers start_speck with eqz. Start seen at edge N gives eqz after edge N+ROUNDS.
// Start must drop for one cycle between jobs. Define SPECK_ABORT_EN to let a start drop during RUN abort the job.
module speck_datapath_responder #(
    parameter int ROUNDS = 27
) (
    input  logic                        clk,
    input  logic                        reset_1,
    speck_datapath_responder_if.slave   bus
);

    localparam int RC_W = $clog2(ROUNDS + 1);

`ifdef SPECK_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [RC_W-1:0]   rc_q;
    logic [31:0]       x_q, y_q, k_q, l_q;
    logic [31:0]       x_d, y_d, k_d, l_d;
    logic [63:0]       y_out_q;
    logic              eqz_q;
    logic              busy_q;
    logic              last_round;

    // One round of the data path and the key schedule. The key schedule feeds the next round.
    always_comb begin
        x_d = ({x_q[7:0], x_q[31:8]} + y_q) ^ k_q;
        y_d = {y_q[28:0], y_q[31:29]} ^ x_d;
        l_d = (k_q + {l_q[7:0], l_q[31:8]}) ^ 32'(rc_q);
        k_d = {k_q[28:0], k_q[31:29]} ^ l_d;
    end

    assign last_round = (rc_q == RC_W'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (!reset_1) begin
            state_q <= IDLE;
            rc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            l_q     <= '0;
            y_out_q <= '0;
            eqz_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    eqz_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start_speck) begin
                        x_q     <= bus.X[63:32];
                        y_q     <= bus.X[31:0];
                        l_q     <= bus.K1[63:32];
                        k_q     <= bus.K1[31:0];
                        rc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (ABORT_EN && !bus.start_speck) begin
                        // Abandon the job. The previous ciphertext stays visible.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        x_q <= x_d;
                        y_q <= y_d;
                        l_q <= l_d;
                        k_q <= k_d;
                        if (last_round) begin
                            y_out_q <= {x_d, y_d};
                            busy_q  <= 1'b0;
                            eqz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rc_q <= rc_q + RC_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!bus.start_speck) begin
                        eqz_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    eqz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.eqz   = eqz_q;
    assign bus.busy  = busy_q;
    assign bus.Y_out = y_out_q;

endmodule
